pc_fetch_stage: RTL and testbench
=================================

Name: pc_fetch_stage

Overview:
- Fetch stage feeding the datapath's next-PC/operand muxes: holds the program counter, requests instructions from instruction memory over a req/ack handshake, and presents the fetched instruction with its PC and PC+4.
- Downstream stages either consume the instruction, stall it, or redirect the PC on a taken branch or jump.
- PC+4 and the redirect target are the two candidates the downstream 32-bit 2:1 mux selects between.

Parameters:
- WIDTH, 32, data and address width of PC, instruction, and memory bus.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INC, 4, PC increment per sequential fetch.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  registered; high while a fetch is outstanding.
- imem_addr  out  WIDTH  equals current pc; valid whenever imem_req=1.
- imem_ack  in  1  memory returns imem_data for imem_addr this cycle; ignored when imem_req=0.
- imem_data  in  WIDTH  instruction word; sampled only when imem_req & imem_ack.
- stall  in  1  downstream cannot accept the instruction this cycle.
- redirect  in  1  single-cycle pulse: taken branch or jump.
- redirect_pc  in  WIDTH  new PC, sampled when redirect=1.
- ir  out  WIDTH  fetched instruction.
- ir_pc  out  WIDTH  address ir was fetched from.
- ir_pc4  out  WIDTH  ir_pc + INC, truncated to WIDTH.
- ir_valid  out  1  ir, ir_pc and ir_pc4 are valid.
- pc  out  WIDTH  current fetch PC.

Behaviour:
- Reset: clk and reset; reset is synchronous and active-high. While reset=1 at a clk edge:
  - pc <= RESET_PC; state <= IDLE.
  - imem_req, ir_valid <= 0; ir, ir_pc, ir_pc4 <= 0.
  - Reset mid-fetch or mid-hold abandons everything; any ack in that cycle is ignored.
- States: IDLE, REQ, OUT. All outputs are registered.
- IDLE:
  - imem_req=0.
  - Next cycle goes to REQ and drives imem_req=1, imem_addr=pc.
  - redirect in IDLE loads pc<=redirect_pc, then goes to REQ.
- REQ: imem_req=1, imem_addr=pc. Memory samples the address combinationally and may ack in any cycle, including the first cycle imem_req is high. Priority is redirect > ack > wait:
  - redirect=1, with or without ack: pc<=redirect_pc; stay REQ; any returned data is discarded; ir_valid stays 0.
  - ack=1, no redirect:
    - ir<=imem_data; ir_pc<=pc; ir_pc4<=pc+INC; ir_valid<=1.
    - pc<=pc+INC, wrapping modulo 2^WIDTH (32'hFFFF_FFFC+4 = 0).
    - Go to OUT; imem_req<=0.
  - Otherwise: hold state, pc and address.
- OUT: ir_valid=1, imem_req=0.
  - redirect=1: ir_valid<=0; pc<=redirect_pc; go REQ. Redirect overrides stall.
  - stall=1, no redirect: hold ir, ir_pc, ir_pc4 and ir_valid unchanged.
  - stall=0: the instruction is consumed this cycle; ir_valid<=0; go REQ.
- Transfer rule: an instruction is delivered exactly once, on the cycle ir_valid=1 and stall=0 and redirect=0. A redirected or discarded fetch is never delivered.
- Throughput:
  - One instruction per 2 cycles with zero-wait memory and no stall.
  - Latency from req rise to ir_valid is (ack cycle + 1).
- stall is ignored in IDLE and REQ; it only gates OUT.
- Never more than one outstanding request. imem_addr never changes while imem_req=1 except on redirect.

Test Plan:
- Reset, then ack every REQ cycle, stall=0 → imem_addr sequence 0,4,8,12. ir_valid pulses every 2nd cycle. ir_pc/ir_pc4 = 0/4, 4/8, 8/12. ir equals the returned words (e.g. 32'h2002_0005).
- Hold ack low 3 cycles at pc=8 → imem_req stays 1 and imem_addr stays 8 all 3 cycles. ir_valid=0 until the cycle after ack. pc advances to 12 only on ack.
- stall=1 for 4 cycles while ir_valid=1 (ir=32'hDEAD_BEEF, ir_pc=4) → outputs frozen, imem_req=0. On stall release, delivered exactly once, then fetch resumes at 8.
- redirect=1, redirect_pc=32'h0000_0100, in the same cycle as ack (imem_data=32'h1111_1111) → data discarded, ir_valid stays 0. Next imem_addr=0x100; first delivered ir_pc=0x100.
- redirect during OUT with stall=1 → ir_valid drops next cycle, held instruction never delivered, fetch restarts at redirect_pc.
- Ack at pc=32'hFFFF_FFFC → ir_pc4=0, next imem_addr=0. Separately, assert reset during REQ with ack=1 → pc=RESET_PC, ir_valid=0, imem_req=0 next cycle.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - PC fetch stage: one outstanding imem request, held instruction with PC and PC+INC
module pc_fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               INC      = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_data,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] ir,
  output logic [WIDTH-1:0] ir_pc,
  output logic [WIDTH-1:0] ir_pc4,
  output logic             ir_valid,
  output logic [WIDTH-1:0] pc
);

  typedef enum logic [1:0] {IDLE, REQ, OUT} state_t;

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  state_t           state, state_nxt;
  logic             req_nxt, valid_nxt;
  logic [WIDTH-1:0] pc_nxt, ir_nxt, ir_pc_nxt, ir_pc4_nxt;

  // The address is the PC register itself, so it can only move on ack or redirect.
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      imem_req <= 1'b0;
      ir_valid <= 1'b0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_pc4   <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      imem_req <= req_nxt;
      ir_valid <= valid_nxt;
      ir       <= ir_nxt;
      ir_pc    <= ir_pc_nxt;
      ir_pc4   <= ir_pc4_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    req_nxt    = imem_req;
    valid_nxt  = ir_valid;
    ir_nxt     = ir;
    ir_pc_nxt  = ir_pc;
    ir_pc4_nxt = ir_pc4;
    case (state)
      IDLE: begin
        if (redirect) pc_nxt = redirect_pc;
        state_nxt = REQ;
        req_nxt   = 1'b1;
      end
      REQ: begin
        // Redirect wins over a same-cycle ack; the returned word is dropped.
        if (redirect) begin
          pc_nxt = redirect_pc;
        end else if (imem_ack) begin
          ir_nxt     = imem_data;
          ir_pc_nxt  = pc;
          ir_pc4_nxt = pc + INC_W;
          valid_nxt  = 1'b1;
          pc_nxt     = pc + INC_W;
          req_nxt    = 1'b0;
          state_nxt  = OUT;
        end
      end
      OUT: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          valid_nxt = 1'b0;
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end else if (!stall) begin
          valid_nxt = 1'b0;
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - directed vector table plus randomized run against a reference model
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, imem_ack, stall, redirect;
  logic [31:0] imem_data, redirect_pc;
  logic        imem_req, ir_valid;
  logic [31:0] imem_addr, ir, ir_pc, ir_pc4, pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_stage #(.WIDTH(32), .RESET_PC(32'h0), .INC(4)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .ir(ir), .ir_pc(ir_pc),
    .ir_pc4(ir_pc4), .ir_valid(ir_valid), .pc(pc)
  );

  typedef struct {
    logic        rst, ack;
    logic [31:0] data;
    logic        stl, rdr;
    logic [31:0] rpc;
    logic        req, vld;
    logic [31:0] ir, irpc, irpc4, pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic ack, input logic [31:0] data,
                              input logic stl, input logic rdr, input logic [31:0] rpc,
                              input logic req, input logic vld, input logic [31:0] e_ir,
                              input logic [31:0] e_irpc, input logic [31:0] e_irpc4,
                              input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.ack = ack; v.data = data; v.stl = stl; v.rdr = rdr; v.rpc = rpc;
    v.req = req; v.vld = vld; v.ir = e_ir; v.irpc = e_irpc; v.irpc4 = e_irpc4; v.pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, then sample one step after the rising edge.
  task automatic drive(input logic rst, input logic ack, input logic [31:0] data,
                       input logic stl, input logic rdr, input logic [31:0] rpc);
    @(negedge clk);
    reset = rst; imem_ack = ack; imem_data = data;
    stall = stl; redirect = rdr; redirect_pc = rpc;
  endtask

  // Reference model: what has been fetched, what is held, and whether a request is open.
  logic        m_idle, m_busy, m_held;
  logic [31:0] m_pc, m_ir, m_irpc, m_irpc4;
  int          m_deliv, d_deliv;

  task automatic model_step(input logic rst, input logic ack, input logic [31:0] data,
                            input logic stl, input logic rdr, input logic [31:0] rpc);
    if (rst) begin
      m_pc = 32'h0; m_idle = 1'b1; m_busy = 1'b0; m_held = 1'b0;
      m_ir = 32'h0; m_irpc = 32'h0; m_irpc4 = 32'h0;
    end else if (m_idle) begin
      if (rdr) m_pc = rpc;
      m_idle = 1'b0; m_busy = 1'b1;
    end else if (m_busy) begin
      if (rdr) m_pc = rpc;
      else if (ack) begin
        m_ir = data; m_irpc = m_pc; m_irpc4 = m_pc + 32'd4;
        m_pc = m_pc + 32'd4; m_held = 1'b1; m_busy = 1'b0;
      end
    end else if (m_held) begin
      if (!rdr && !stl) m_deliv++;
      if (rdr) m_pc = rpc;
      if (rdr || !stl) begin
        m_held = 1'b0; m_busy = 1'b1;
      end
    end
  endtask

  initial begin
    vec_t v;
    logic rst, ack, stl, rdr;
    logic [31:0] data, rpc;

    reset = 1'b1; imem_ack = 1'b0; imem_data = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    //            rst ack data           stl rdr rpc            req vld ir             ir_pc          ir_pc4         pc
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,          0, 0, 32'h0,        32'h0,        32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,          1, 0, 32'h0,        32'h0,        32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 32'h2002_0005,0, 0, 32'h0,          0, 1, 32'h2002_0005,32'h0,        32'h4,        32'h4));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,          1, 0, 32'h2002_0005,32'h0,        32'h4,        32'h4));
    vecs.push_back(mk(0, 1, 32'hDEAD_BEEF,0, 0, 32'h0,          0, 1, 32'hDEAD_BEEF,32'h4,        32'h8,        32'h8));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 1, 32'h0,      1, 0, 32'h0,          0, 1, 32'hDEAD_BEEF,32'h4,        32'h8,        32'h8));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,          1, 0, 32'hDEAD_BEEF,32'h4,        32'h8,        32'h8));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 0, 32'h0,      1, 0, 32'h0,          1, 0, 32'hDEAD_BEEF,32'h4,        32'h8,        32'h8));
    vecs.push_back(mk(0, 1, 32'h0000_0013,0, 0, 32'h0,          0, 1, 32'h0000_0013,32'h8,        32'hC,        32'hC));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,          1, 0, 32'h0000_0013,32'h8,        32'hC,        32'hC));
    vecs.push_back(mk(0, 1, 32'h1111_1111,0, 1, 32'h100,        1, 0, 32'h0000_0013,32'h8,        32'hC,        32'h100));
    vecs.push_back(mk(0, 1, 32'hAAAA_0001,0, 0, 32'h0,          0, 1, 32'hAAAA_0001,32'h100,      32'h104,      32'h104));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC,  1, 0, 32'hAAAA_0001,32'h100,      32'h104,      32'hFFFF_FFFC));
    vecs.push_back(mk(0, 1, 32'h0000_0005,0, 0, 32'h0,          0, 1, 32'h0000_0005,32'hFFFF_FFFC,32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,          1, 0, 32'h0000_0005,32'hFFFF_FFFC,32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 32'h7777_7777,0, 0, 32'h0,          0, 0, 32'h0,        32'h0,        32'h0,        32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rst, v.ack, v.data, v.stl, v.rdr, v.rpc);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, v.req});
      chk($sformatf("v%0d ir_valid", i), {31'b0, ir_valid}, {31'b0, v.vld});
      chk($sformatf("v%0d pc", i), pc, v.pc);
      chk($sformatf("v%0d ir", i), ir, v.ir);
      chk($sformatf("v%0d ir_pc", i), ir_pc, v.irpc);
      chk($sformatf("v%0d ir_pc4", i), ir_pc4, v.irpc4);
      if (v.req) chk($sformatf("v%0d imem_addr", i), imem_addr, v.pc);
    end

    m_deliv = 0; d_deliv = 0;
    for (int c = 0; c < 2000; c++) begin
      rst  = (c == 0) || ($urandom_range(0, 63) == 0);
      ack  = $urandom_range(0, 1) == 1;
      data = $urandom;
      stl  = $urandom_range(0, 2) == 0;
      rdr  = $urandom_range(0, 7) == 0;
      rpc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : {$urandom_range(0, 32'h3FFF), 2'b00};
      drive(rst, ack, data, stl, rdr, rpc);
      if (ir_valid && !stl && !rdr && !rst) d_deliv++;
      @(posedge clk);
      #1;
      model_step(rst, ack, data, stl, rdr, rpc);
      chk($sformatf("r%0d imem_req", c), {31'b0, imem_req}, {31'b0, m_busy});
      chk($sformatf("r%0d ir_valid", c), {31'b0, ir_valid}, {31'b0, m_held});
      chk($sformatf("r%0d pc", c), pc, m_pc);
      if (m_busy) chk($sformatf("r%0d imem_addr", c), imem_addr, m_pc);
      chk($sformatf("r%0d ir", c), ir, m_ir);
      chk($sformatf("r%0d ir_pc", c), ir_pc, m_irpc);
      chk($sformatf("r%0d ir_pc4", c), ir_pc4, m_irpc4);
    end
    chk("delivery_count", d_deliv, m_deliv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
